// File: rtl/qvga_frame_reader.sv
// 640x480@60 raster source reading a 320x240 RGB444 frame buffer,
// 2x pixel/line replicated, coordinates aligned with registered RAM data.
module qvga_frame_reader #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              pclk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [9:0]        x_pixel,
    output logic [9:0]        y_pixel,
    output logic [DATA_W-1:0] data,
    output logic              de,
    output logic              h_sync,
    output logic              v_sync,
    output logic              frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VEND = 10'(H_VIS);
    localparam logic [9:0] V_VEND = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [9:0] r_s1_x;
    logic [9:0] r_s1_y;
    logic [9:0] r_s2_x;
    logic [9:0] r_s2_y;
    logic       r_s1_vld;
    logic       r_s2_vld;

    logic              w_vis;
    logic [ADDR_W-1:0] w_h2;
    logic [ADDR_W-1:0] w_v2;
    logic [ADDR_W-1:0] w_addr;
    logic              w_de;
    logic              w_hs;
    logic              w_vs;
    logic              w_fs;

    assign w_vis  = (r_h < H_VEND) && (r_v < V_VEND);
    assign w_h2   = ADDR_W'(r_h[9:1]);
    assign w_v2   = ADDR_W'(r_v[9:1]);
    // Row stride of 320 words as 256 + 64, so no multiplier is needed.
    assign w_addr = (w_v2 << 8) + (w_v2 << 6) + w_h2;

    assign w_de = r_s2_vld && (r_s2_x < H_VEND) && (r_s2_y < V_VEND);
    assign w_hs = !(r_s2_vld && (r_s2_x >= HS_BEG) && (r_s2_x < HS_END));
    assign w_vs = !(r_s2_vld && (r_s2_y >= VS_BEG) && (r_s2_y < VS_END));
    assign w_fs = r_s2_vld && (r_s2_x == 10'd0) && (r_s2_y == 10'd0);

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    // Stage 1 issues the read; stage 2 lines coordinates up with rd_data.
    always_ff @(posedge pclk) begin
        if (reset) begin
            rd_addr  <= '0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_vld <= 1'b0;
            r_s2_x   <= '0;
            r_s2_y   <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            rd_addr  <= w_vis ? w_addr : '0;
            r_s1_x   <= r_h;
            r_s1_y   <= r_v;
            r_s1_vld <= 1'b1;
            r_s2_x   <= r_s1_x;
            r_s2_y   <= r_s1_y;
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            x_pixel     <= '0;
            y_pixel     <= '0;
            data        <= '0;
            de          <= 1'b0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            x_pixel     <= r_s2_x;
            y_pixel     <= r_s2_y;
            data        <= w_de ? rd_data : '0;
            de          <= w_de;
            h_sync      <= w_hs;
            v_sync      <= w_vs;
            frame_start <= w_fs;
        end
    end

endmodule

// File: tb/tb_qvga_frame_reader.sv
// Scoreboard bench for qvga_frame_reader: full horizontal timing,
// vertical geometry shortened so two whole frames fit in the run.
module tb_qvga_frame_reader;

    localparam int VV    = 8;
    localparam int VFP   = 2;
    localparam int VSY   = 2;
    localparam int VBP   = 2;
    localparam int VTOT  = VV + VFP + VSY + VBP;
    localparam int HTOT  = 800;
    localparam int FRAME = HTOT * VTOT;

    localparam logic [35:0] RST_V =
        {10'd0, 10'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic        pclk;
    logic        reset;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic [9:0]  x_pixel;
    logic [9:0]  y_pixel;
    logic [11:0] data;
    logic        de;
    logic        h_sync;
    logic        v_sync;
    logic        frame_start;

    qvga_frame_reader #(
        .V_VIS (VV),
        .V_FP  (VFP),
        .V_SYNC(VSY),
        .V_BP  (VBP)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .data       (data),
        .de         (de),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .frame_start(frame_start)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Registered frame buffer returning the low address bits as data.
    always @(posedge pclk) rd_data <= rd_addr[11:0];

    int n_chk;
    int n_fail;
    int mh;
    int mv;
    int cyc;
    int hs_run;
    int vs_run;
    int last_fs;
    bit fs_seen;
    logic [35:0] q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int src_addr(input int h, input int v);
        if (h < 640 && v < VV) return (v / 2) * 320 + h / 2;
        return 0;
    endfunction

    function automatic logic [35:0] mk(input int h, input int v);
        logic        e_de;
        logic [11:0] e_d;
        logic        e_hs;
        logic        e_vs;
        logic        e_fs;
        int          a;
        e_de = (h < 640) && (v < VV);
        a    = src_addr(h, v);
        e_d  = e_de ? a[11:0] : 12'd0;
        e_hs = !(h >= 656 && h < 752);
        e_vs = !(v >= VV + VFP && v < VV + VFP + VSY);
        e_fs = (h == 0) && (v == 0);
        return {10'(h), 10'(v), e_d, e_de, e_hs, e_vs, e_fs};
    endfunction

    task automatic step();
        int ea;
        ea = 0;
        @(posedge pclk);
        cyc++;
        if (!reset) begin
            q.push_back(mk(mh, mv));
            ea = src_addr(mh, mv);
            if (mh == 5 && mv == 7) ea = 962;
            if (mh == HTOT - 1) begin
                mh = 0;
                mv = (mv == VTOT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        #1;
        if (reset) begin
            chk("rst_out", {x_pixel, y_pixel, data, de, h_sync, v_sync,
                frame_start}, RST_V);
            chk("rst_addr", rd_addr, 0);
            q.delete();
            q.push_back(RST_V);
            q.push_back(RST_V);
            mh = 0;
            mv = 0;
            hs_run = 0;
            vs_run = 0;
            fs_seen = 0;
        end else begin
            if (q.size() == 0) begin
                chk("q_underflow", 0, 1);
            end else begin
                chk("out", {x_pixel, y_pixel, data, de, h_sync, v_sync,
                    frame_start}, q.pop_front());
            end
            chk("rd_addr", rd_addr, ea);
            chk("addr_max", rd_addr <= 17'd76799, 1);
            if (!h_sync) begin
                if (hs_run == 0) chk("hs_start_x", x_pixel, 656);
                hs_run++;
            end else if (hs_run != 0) begin
                chk("hs_width", hs_run, 96);
                hs_run = 0;
            end
            if (!v_sync) begin
                if (vs_run == 0) chk("vs_start_y", y_pixel, VV + VFP);
                vs_run++;
            end else if (vs_run != 0) begin
                chk("vs_width", vs_run, VSY * HTOT);
                vs_run = 0;
            end
            if (frame_start) begin
                if (fs_seen) chk("frame_period", cyc - last_fs, FRAME);
                fs_seen = 1;
                last_fs = cyc;
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        mh      = 0;
        mv      = 0;
        cyc     = 0;
        hs_run  = 0;
        vs_run  = 0;
        last_fs = 0;
        fs_seen = 0;
        reset   = 1'b1;
        repeat (5) step();
        reset = 1'b0;
        step();
        step();
        step();
        chk("first_fs", {x_pixel, y_pixel, de, frame_start, data},
            {10'd0, 10'd0, 1'b1, 1'b1, 12'h000});
        repeat (2 * FRAME + 20) step();

        for (int i = 0; i < FRAME; i++) begin
            if (x_pixel == 10'd300 && y_pixel == 10'd5) break;
            step();
        end
        chk("reach_300_5", {x_pixel, y_pixel}, {10'd300, 10'd5});
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        chk("restart_idle", {de, frame_start, h_sync, v_sync}, 4'b0011);
        step();
        chk("restart_fs", {x_pixel, y_pixel, de, frame_start},
            {10'd0, 10'd0, 1'b1, 1'b1});
        repeat (2000) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
